// File: rtl/mux_nx1_sync.sv
// Registered N:1 valid/ready mux: DIRECT (external select) or SCAN (round-robin from PTR+1).
// Latency: 1 clock from input handshake to out_valid. Backpressure: the output register holds and in_ready stays 0 while out_valid & !out_ready.
module mux_nx1_sync #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int NP = 2 ** SELW;
    localparam logic [SELW:0] NW = (SELW + 1)'(N);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t mode_state;

    logic [SELW-1:0] ptr_q;
    logic [NP-1:0]   valid_pad;
    logic [NP*W-1:0] data_pad;

    logic            load;
    logic            switching;
    logic            sel_ok;
    logic            direct_hit;
    logic            scan_hit;
    logic [SELW-1:0] scan_k;
    logic [SELW:0]   scan_idx;
    logic [SELW-1:0] pick;
    logic            capture;

    // Padding to a power of two keeps every select in range, even for SEL >= N.
    assign valid_pad = NP'(in_valid);
    assign data_pad  = (NP * W)'(in_data);

    assign load       = !out_valid || out_ready;
    assign mode_state = mode ? ST_SCAN : ST_DIRECT;
    assign switching  = load && (mode_state != state_q);
    assign sel_ok     = ({1'b0, sel} < NW);
    assign direct_hit = sel_ok && valid_pad[sel];

    // Search PTR+1 .. PTR+N with modulo-N wrap, so PTR itself is checked last.
    always_comb begin
        scan_hit = 1'b0;
        scan_k   = '0;
        scan_idx = '0;
        for (int i = 1; i <= N; i++) begin
            scan_idx = {1'b0, ptr_q} + (SELW + 1)'(i);
            if (scan_idx >= NW) begin
                scan_idx = scan_idx - NW;
            end
            if (!scan_hit && valid_pad[scan_idx[SELW-1:0]]) begin
                scan_hit = 1'b1;
                scan_k   = scan_idx[SELW-1:0];
            end
        end
    end

    always_comb begin
        pick    = sel;
        capture = 1'b0;
        if (state_q == ST_SCAN) begin
            pick = scan_k;
        end
        if (!rst && load && !switching) begin
            capture = (state_q == ST_SCAN) ? scan_hit : direct_hit;
        end
        in_ready = capture ? (N'(1) << pick) : '0;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = mode_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DIRECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ptr_q     <= SELW'(N - 1);
        end else begin
            if (state_q == ST_DIRECT && !sel_ok) begin
                err <= 1'b1;
            end
            if (capture) begin
                out_data  <= data_pad[pick*W +: W];
                out_ch    <= pick;
                out_valid <= 1'b1;
                if (state_q == ST_SCAN) begin
                    ptr_q <= pick;
                end
            end else if (load) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_sync.sv
// Bench for mux_nx1_sync: an N=8 instance checked against a cycle model, plus an N=6 instance for range/wrap cases.
module tb_mux_nx1_sync;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int SELW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [SELW-1:0]  sel;
    logic             mode;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    logic [6*W-1:0]   b_in_data;
    logic [5:0]       b_in_valid;
    logic [5:0]       b_in_ready;
    logic [2:0]       b_sel;
    logic             b_mode;
    logic [W-1:0]     b_out_data;
    logic [2:0]       b_out_ch;
    logic             b_out_valid;
    logic             b_out_ready;
    logic             b_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         m_vld;
    bit         m_err;
    bit         m_scan;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    always #5 clk = ~clk;

    mux_nx1_sync #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    mux_nx1_sync #(.N(6), .W(8), .SELW(3)) dut6 (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .mode(b_mode), .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .err(b_err)
    );

    function automatic void model_reset();
        m_vld  = 1'b0;
        m_err  = 1'b0;
        m_scan = 1'b0;
        m_data = 8'h00;
        m_ch   = 0;
        m_ptr  = N - 1;
    endfunction

    // Channel the specification says is taken this cycle, or -1.
    function automatic int model_pick();
        bit load;
        load = !m_vld || out_ready;
        if (rst || !load || (mode != m_scan)) return -1;
        if (!m_scan) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int j = 1; j <= N; j++) begin
            if (in_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int k;
        k = model_pick();
        return (k < 0) ? '0 : (N'(1) << k);
    endfunction

    task automatic tick();
        int k;
        bit load;
        k    = model_pick();
        load = !m_vld || out_ready;
        if (!rst) begin
            if (!m_scan && int'(sel) >= N) m_err = 1'b1;
            if (k >= 0) begin
                m_data = in_data[k*W +: W];
                m_ch   = k;
                m_vld  = 1'b1;
                if (m_scan) m_ptr = k;
            end else if (load) begin
                m_vld = 1'b0;
            end
            if (load) m_scan = mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_data = {$urandom, $urandom};
        in_valid = '1; sel = '0; mode = 1'b0; out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_mode = 1'b0; b_out_ready = 1'b1;
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({out_data, out_ch, out_valid, err} !== '0) begin failures++;
            $display("FAIL reset_outputs got data=%h ch=%0d vld=%b err=%b want all 0", out_data, out_ch, out_valid, err); end
        checks++; if (in_ready !== '0 || b_in_ready !== '0) begin failures++;
            $display("FAIL reset_ready got %h/%h want 0/0", in_ready, b_in_ready); end
        tick();
        checks++; if (in_ready !== '0 || out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_held got rdy=%h vld=%b want 0/0", in_ready, out_valid); end
        rst = 1'b0;
        in_valid = '0;
    endtask

    task automatic test_direct();
        mode = 1'b0; sel = 3'd5; in_valid = 8'h20; out_ready = 1'b1;
        in_data = {$urandom, $urandom};
        in_data[5*W +: W] = 8'hA5;
        #1;
        checks++; if (in_ready !== 8'h20 || in_ready !== model_ready()) begin failures++;
            $display("FAIL direct_ready got %h want 20", in_ready); end
        tick();
        checks++; if (out_data !== 8'hA5 || out_ch !== 3'd5 || out_valid !== 1'b1) begin failures++;
            $display("FAIL direct_out got data=%h ch=%0d vld=%b want a5/5/1", out_data, out_ch, out_valid); end
    endtask

    task automatic test_backpressure();
        sel = 3'd2; in_valid = 8'h04; out_ready = 1'b1;
        in_data[2*W +: W] = 8'h3C;
        #1 tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data[2*W +: W] = 8'($urandom);
            #1;
            checks++; if (in_ready !== '0) begin failures++;
                $display("FAIL bp_ready cycle %0d got %h want 0", i, in_ready); end
            tick();
            checks++; if (out_data !== 8'h3C || out_ch !== 3'd2 || out_valid !== 1'b1) begin failures++;
                $display("FAIL bp_hold cycle %0d got data=%h ch=%0d vld=%b want 3c/2/1", i, out_data, out_ch, out_valid); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[2*W +: W] = 8'(8'h40 + i);
            #1;
            checks++; if (in_ready !== 8'h04) begin failures++;
                $display("FAIL b2b_ready cycle %0d got %h want 04", i, in_ready); end
            tick();
            checks++; if (out_data !== 8'(8'h40 + i) || out_valid !== 1'b1) begin failures++;
                $display("FAIL b2b_out cycle %0d got data=%h vld=%b want %h/1", i, out_data, out_valid, 8'(8'h40 + i)); end
        end
    endtask

    task automatic test_scan();
        int seq [6] = '{0, 2, 7, 0, 2, 7};
        logic [7:0] expd;
        mode = 1'b1; in_valid = 8'h85; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== '0) begin failures++;
            $display("FAIL scan_bubble got %h want 0", in_ready); end
        tick();
        for (int i = 0; i < 6; i++) begin
            in_data = {$urandom, $urandom};
            expd = in_data[seq[i]*W +: W];
            #1;
            checks++; if (in_ready !== (N'(1) << seq[i])) begin failures++;
                $display("FAIL scan_ready step %0d got %h want ch %0d", i, in_ready, seq[i]); end
            tick();
            checks++; if (int'(out_ch) !== seq[i] || out_data !== expd || out_valid !== 1'b1) begin failures++;
                $display("FAIL scan_out step %0d got ch=%0d data=%h vld=%b want %0d/%h/1", i, out_ch, out_data, out_valid, seq[i], expd); end
        end
    endtask

    task automatic test_scan_idle();
        in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 tick();
            checks++; if (out_valid !== 1'b0 || out_ch !== 3'd7) begin failures++;
                $display("FAIL idle_drain cycle %0d got vld=%b ch=%0d want 0/7", i, out_valid, out_ch); end
        end
        in_valid = 8'h80;
        #1 tick();
        checks++; if (out_ch !== 3'd7 || out_valid !== 1'b1) begin failures++;
            $display("FAIL idle_reselect got ch=%0d vld=%b want 7/1", out_ch, out_valid); end
        in_valid = 8'h81;
        #1 tick();
        checks++; if (out_ch !== 3'd0) begin failures++;
            $display("FAIL idle_ptr_next got ch=%0d want 0", out_ch); end
    endtask

    task automatic test_reset_mid();
        in_valid = 8'hFF; out_ready = 1'b0;
        #1 tick();
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({out_data, out_ch, out_valid} !== '0 || in_ready !== '0) begin failures++;
            $display("FAIL midreset got data=%h ch=%0d vld=%b rdy=%h want all 0", out_data, out_ch, out_valid, in_ready); end
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== '0) begin failures++;
            $display("FAIL midreset_bubble got %h want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 8'h01) begin failures++;
            $display("FAIL midreset_first_ready got %h want 01", in_ready); end
        tick();
        checks++; if (out_ch !== 3'd0 || out_valid !== 1'b1) begin failures++;
            $display("FAIL midreset_first_ch got ch=%0d vld=%b want 0/1", out_ch, out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = SELW'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            checks++; if (in_ready !== model_ready()) begin failures++;
                $display("FAIL rand_ready cycle %0d got %h want %h", i, in_ready, model_ready()); end
            tick();
            checks++; if (out_valid !== m_vld || out_data !== m_data || int'(out_ch) !== m_ch || err !== m_err) begin failures++;
                $display("FAIL rand_out cycle %0d got vld=%b data=%h ch=%0d err=%b want %b/%h/%0d/%b",
                         i, out_valid, out_data, out_ch, err, m_vld, m_data, m_ch, m_err); end
        end
    endtask

    task automatic test_n6_err();
        b_mode = 1'b0; b_sel = 3'd7; b_in_valid = 6'h3F; b_out_ready = 1'b1;
        b_in_data = {$urandom, $urandom};
        #1;
        checks++; if (b_in_ready !== '0 || b_err !== 1'b0) begin failures++;
            $display("FAIL n6_badsel got rdy=%h err=%b want 0/0", b_in_ready, b_err); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_err !== 1'b1 || b_in_ready !== '0 || b_out_valid !== 1'b0) begin failures++;
                $display("FAIL n6_err cycle %0d got err=%b rdy=%h vld=%b want 1/0/0", i, b_err, b_in_ready, b_out_valid); end
        end
        b_sel = 3'd3;
        b_in_data[3*8 +: 8] = 8'h5A;
        #1;
        checks++; if (b_in_ready !== 6'h08) begin failures++;
            $display("FAIL n6_sel3_ready got %h want 08", b_in_ready); end
        tick();
        checks++; if (b_out_data !== 8'h5A || b_out_ch !== 3'd3 || b_out_valid !== 1'b1 || b_err !== 1'b1) begin failures++;
            $display("FAIL n6_sel3_out got data=%h ch=%0d vld=%b err=%b want 5a/3/1/1", b_out_data, b_out_ch, b_out_valid, b_err); end
    endtask

    task automatic test_n6_scan();
        int seq [4] = '{0, 5, 0, 5};
        b_mode = 1'b1; b_in_valid = 6'b100001; b_out_ready = 1'b1;
        #1 tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (b_in_ready !== (6'd1 << seq[i])) begin failures++;
                $display("FAIL n6_scan_ready step %0d got %h want ch %0d", i, b_in_ready, seq[i]); end
            tick();
            checks++; if (int'(b_out_ch) !== seq[i] || b_out_valid !== 1'b1) begin failures++;
                $display("FAIL n6_scan_out step %0d got ch=%0d vld=%b want %0d/1", i, b_out_ch, b_out_valid, seq[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_backpressure();
        test_scan();
        test_scan_idle();
        test_reset_mid();
        test_random();
        test_n6_err();
        test_n6_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
